// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device model answering a 16-bit controller from folded on-chip storage
module sdram_responder #(
  parameter int COL_BITS      = 10,
  parameter int ROW_FOLD_BITS = 2,
  parameter int DEFAULT_CL    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] sdram_addr,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic        sdram_cke,
  input  logic [1:0]  sdram_dqm,
  input  logic [15:0] sdram_dq_in,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        init_done,
  output logic        err_flag,
  output logic [15:0] refresh_count
);
  localparam int AW = 2 + ROW_FOLD_BITS + COL_BITS;
  typedef enum logic {UNINIT, READY} state_t;
  state_t state_q;
  logic [3:0] open_q;
  logic [ROW_FOLD_BITS-1:0] row_q [4];
  logic [15:0] mem [2**AW];
  logic cl3_q;
  logic [2:0] v_q;
  logic [15:0] d_q [3];
  logic [15:0] dq_out_q, ref_q;
  logic dq_oe_q, err_q;
  logic [3:0] cmd;
  logic act, rd, wr, pre, refr, lmr, rdy, bank_open, pending, slot_v;
  logic [AW-1:0] idx;
  logic unused_ok;
  assign cmd       = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign act       = cmd == 4'b0011;
  assign rd        = cmd == 4'b0101;
  assign wr        = cmd == 4'b0100;
  assign pre       = cmd == 4'b0010;
  assign refr      = cmd == 4'b0001;
  assign lmr       = cmd == 4'b0000;
  assign rdy       = state_q == READY;
  assign bank_open = open_q[sdram_ba];
  assign idx       = {sdram_ba, row_q[sdram_ba], sdram_addr[COL_BITS-1:0]};
  // Reads still owed to the bus: stage 3 only feeds the output at CL=3
  assign pending   = v_q[0] | v_q[1] | (cl3_q & v_q[2]);
  // The read in stage 2 is two cycles old, so this cycle's dqm can blank its slot
  assign slot_v    = v_q[1] & ~&sdram_dqm;
  assign unused_ok = ^{sdram_addr[12:11], sdram_addr[3]};
  assign sdram_dq_out  = dq_out_q;
  assign sdram_dq_oe   = dq_oe_q;
  assign init_done     = state_q == READY;
  assign err_flag      = err_q;
  assign refresh_count = ref_q;
  // Byte-masked write into storage; contents deliberately survive reset
  always_ff @(posedge clk)
    if (!reset && sdram_cke && wr && rdy && bank_open) begin
      if (!sdram_dqm[0]) mem[idx][7:0]  <= sdram_dq_in[7:0];
      if (!sdram_dqm[1]) mem[idx][15:8] <= sdram_dq_in[15:8];
    end
  // Command decode, bank tracking, mode register and the CAS-latency read pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= UNINIT;
      open_q   <= '0;
      cl3_q    <= (DEFAULT_CL == 3);
      err_q    <= 1'b0;
      ref_q    <= '0;
      v_q      <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
    end else if (sdram_cke) begin
      v_q      <= {slot_v, v_q[0], rd & rdy & bank_open};
      d_q[0]   <= mem[idx];
      d_q[1]   <= d_q[0];
      d_q[2]   <= d_q[1];
      dq_oe_q  <= cl3_q ? v_q[2] : slot_v;
      dq_out_q <= cl3_q ? d_q[2] : d_q[1];
      if ((act | rd | wr) && !rdy) err_q <= 1'b1;
      if ((rd | wr) && rdy && !bank_open) err_q <= 1'b1;
      if (wr && pending) err_q <= 1'b1;
      if (act && rdy) begin
        open_q[sdram_ba] <= 1'b1;
        row_q[sdram_ba]  <= sdram_addr[ROW_FOLD_BITS-1:0];
        if (bank_open) err_q <= 1'b1;
      end
      if (pre) begin
        if (sdram_addr[10]) open_q <= '0;
        else open_q[sdram_ba] <= 1'b0;
      end
      if (refr) begin
        ref_q <= ref_q + 16'd1;
        if (|open_q) err_q <= 1'b1;
      end
      if (lmr) begin
        state_q <= READY;
        if (sdram_addr[6:4] == 3'd2 || sdram_addr[6:4] == 3'd3) cl3_q <= sdram_addr[4];
        else err_q <= 1'b1;
        if (sdram_addr[2:0] != 3'd0 || |open_q) err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: vector table, directed corner sequences and random traffic against a behavioural model
module tb_sdram_responder;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000, BST = 4'b0110;
  logic clk = 0, reset = 1, cke = 1;
  logic [12:0] addr = 0;
  logic [1:0] ba = 0, dqm = 0;
  logic [15:0] dq_in = 0;
  logic [3:0] cmd = NOP;
  logic [15:0] dq_out, rc;
  logic dq_oe, init_done, err_flag;
  int checks = 0, failures = 0;

  sdram_responder dut (
    .clk(clk), .reset(reset), .sdram_addr(addr), .sdram_ba(ba),
    .sdram_cs_n(cmd[3]), .sdram_ras_n(cmd[2]), .sdram_cas_n(cmd[1]), .sdram_we_n(cmd[0]),
    .sdram_cke(cke), .sdram_dqm(dqm), .sdram_dq_in(dq_in), .sdram_dq_out(dq_out),
    .sdram_dq_oe(dq_oe), .init_done(init_done), .err_flag(err_flag), .refresh_count(rc)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // Behavioural model: reads are scheduled events keyed by a count of enabled clock edges
  typedef struct { int due; int mask_t; logic [15:0] data; bit known; bit masked; } rd_t;
  rd_t pq[$];
  logic [7:0] mb [int];
  bit m_init, m_err, e_oe, e_known;
  bit [3:0] m_open;
  int m_cl, tick, last_rd;
  int m_row [4];
  logic [15:0] m_rc, e_q;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int k, hit;
    bit pend;
    rd_t r;
    if (reset) begin
      m_init = 0; m_err = 0; m_cl = 3; m_open = 0; m_rc = 0;
      pq.delete(); e_oe = 0; e_q = 0; e_known = 1;
      return;
    end
    if (!cke) return;
    tick++;
    pend = 0;
    hit = -1;
    foreach (pq[i]) if (pq[i].due >= tick && !pq[i].masked) pend = 1;
    foreach (pq[i]) begin
      if (pq[i].mask_t == tick && dqm == 2'b11) pq[i].masked = 1;
      if (pq[i].due == tick) hit = i;
    end
    e_oe = 0;
    if (hit >= 0) begin
      e_oe = !pq[hit].masked;
      if (e_oe) begin e_q = pq[hit].data; e_known = pq[hit].known; end
    end
    while (pq.size() > 0 && pq[0].due <= tick) void'(pq.pop_front());
    k = int'(ba) * 4096 + m_row[ba] * 1024 + int'(addr[9:0]);
    case (cmd)
      ACT: if (!m_init) m_err = 1;
           else begin
             if (m_open[ba]) m_err = 1;
             m_open[ba] = 1;
             m_row[ba] = int'(addr[1:0]);
           end
      RD: if (!m_init || !m_open[ba]) m_err = 1;
          else begin
            r.due = tick + m_cl; r.mask_t = tick + 2; r.masked = 0;
            r.known = mb.exists(2*k) && mb.exists(2*k+1);
            r.data = r.known ? {mb[2*k+1], mb[2*k]} : 16'h0;
            pq.push_back(r);
            last_rd = tick;
          end
      WR: if (!m_init) m_err = 1;
          else begin
            if (pend) m_err = 1;
            if (!m_open[ba]) m_err = 1;
            else begin
              if (!dqm[0]) mb[2*k] = dq_in[7:0];
              if (!dqm[1]) mb[2*k+1] = dq_in[15:8];
            end
          end
      PRE: if (addr[10]) m_open = 0; else m_open[ba] = 0;
      REF: begin m_rc = m_rc + 16'd1; if (m_open != 0) m_err = 1; end
      LMR: begin
             m_init = 1;
             if (addr[6:4] == 3'd2 || addr[6:4] == 3'd3) m_cl = int'(addr[6:4]); else m_err = 1;
             if (addr[2:0] != 3'd0 || m_open != 0) m_err = 1;
           end
      default: ;
    endcase
  endtask

  task automatic step(input logic r, input logic ce, input logic [3:0] c, input logic [1:0] b,
                      input logic [12:0] a, input logic [1:0] m, input logic [15:0] d);
    reset = r; cke = ce; cmd = c; ba = b; addr = a; dqm = m; dq_in = d;
    @(posedge clk);
    model_edge();
    #1;
    chk("model dq_oe", 16'(dq_oe), 16'(e_oe));
    if (e_oe && e_known) chk("model dq_out", dq_out, e_q);
    if (r) chk("reset dq_out", dq_out, 16'h0);
    chk("model init_done", 16'(init_done), 16'(m_init));
    chk("model err_flag", 16'(err_flag), 16'(m_err));
    chk("model refresh_count", rc, m_rc);
  endtask

  task automatic go(input logic [3:0] c, input logic [1:0] b = 0, input logic [12:0] a = 0,
                    input logic [15:0] d = 0, input logic [1:0] m = 0);
    step(1'b0, 1'b1, c, b, a, m, d);
  endtask

  task automatic rst();
    step(1'b1, 1'b1, NOP, 2'd0, 13'd0, 2'd0, 16'd0);
  endtask

  typedef struct { logic r; logic [3:0] c; logic [1:0] b; logic [12:0] a; logic [15:0] d;
                   logic oe; logic [15:0] q; logic ini; logic er; } vec_t;
  vec_t tv [14];
  logic [15:0] exp_b [2][9];
  logic [12:0] lm_tab [5];

  initial begin
    tv[0]  = '{1'b1, NOP, 2'd0, 13'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tv[1]  = '{1'b0, RD,  2'd1, 13'h012, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tv[2]  = '{1'b0, NOP, 2'd0, 13'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tv[3]  = '{1'b0, NOP, 2'd0, 13'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tv[4]  = '{1'b0, NOP, 2'd0, 13'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tv[5]  = '{1'b1, NOP, 2'd0, 13'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tv[6]  = '{1'b0, LMR, 2'd0, 13'h030, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[7]  = '{1'b0, ACT, 2'd1, 13'h005, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[8]  = '{1'b0, WR,  2'd1, 13'h012, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[9]  = '{1'b0, RD,  2'd1, 13'h012, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[10] = '{1'b0, NOP, 2'd0, 13'h000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[11] = '{1'b0, NOP, 2'd0, 13'h000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[12] = '{1'b0, NOP, 2'd0, 13'h000, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 1'b0};
    tv[13] = '{1'b0, NOP, 2'd0, 13'h000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    exp_b[0] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0};
    exp_b[1] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
    lm_tab = '{13'h020, 13'h030, 13'h021, 13'h050, 13'h070};
    for (int i = 0; i < 4; i++) m_row[i] = 0;
    tick = 0;
    last_rd = -100;

    for (int i = 0; i < 14; i++) begin
      step(tv[i].r, 1'b1, tv[i].c, tv[i].b, tv[i].a, 2'b00, tv[i].d);
      chk($sformatf("vec%0d dq_oe", i), 16'(dq_oe), 16'(tv[i].oe));
      if (tv[i].oe || tv[i].r) chk($sformatf("vec%0d dq_out", i), dq_out, tv[i].q);
      chk($sformatf("vec%0d init_done", i), 16'(init_done), 16'(tv[i].ini));
      chk($sformatf("vec%0d err_flag", i), 16'(err_flag), 16'(tv[i].er));
    end

    rst();
    go(LMR, 0, 13'h020);
    go(ACT, 0, 13'h001);
    go(WR, 0, 13'h007, 16'h1234);
    go(WR, 0, 13'h007, 16'hABCD, 2'b01);
    go(RD, 0, 13'h007);
    chk("cl2 oe at +0", 16'(dq_oe), 16'd0);
    go(NOP);
    chk("cl2 oe at +1", 16'(dq_oe), 16'd0);
    go(NOP);
    chk("cl2 oe at +2", 16'(dq_oe), 16'd1);
    chk("cl2 merged data", dq_out, 16'hAB34);
    chk("cl2 err_flag", 16'(err_flag), 16'd0);

    rst();
    go(LMR, 0, 13'h030);
    go(ACT, 2, 13'h003);
    for (int i = 0; i < 4; i++) go(WR, 2, 13'(i), 16'(i + 1));
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 9; k++) begin
        if (k < 4) go(RD, 2, 13'(k));
        else step(1'b0, !(p == 1 && k == 4), NOP, 2'd0, 13'd0, 2'd0, 16'd0);
        chk($sformatf("burst%0d oe k%0d", p, k), 16'(dq_oe), 16'(exp_b[p][k] != 0));
        if (exp_b[p][k] != 0) chk($sformatf("burst%0d data k%0d", p, k), dq_out, exp_b[p][k]);
      end

    rst();
    go(LMR, 0, 13'h030);
    go(ACT, 0, 13'h000);
    go(WR, 0, 13'h005, 16'h5555);
    go(PRE, 0, 13'h400);
    repeat (3) go(REF);
    chk("refresh count 3", rc, 16'd3);
    chk("refresh err clean", 16'(err_flag), 16'd0);
    go(WR, 0, 13'h005, 16'hAAAA);
    chk("write closed err", 16'(err_flag), 16'd1);
    go(ACT, 0, 13'h000);
    go(RD, 0, 13'h005);
    repeat (3) go(NOP);
    chk("closed write kept oe", 16'(dq_oe), 16'd1);
    chk("closed write kept data", dq_out, 16'h5555);

    rst();
    go(LMR, 0, 13'h030);
    go(REF);
    go(ACT, 3, 13'h002);
    go(WR, 3, 13'h009, 16'h7777);
    go(RD, 3, 13'h009);
    rst();
    for (int i = 0; i < 5; i++) begin
      go(NOP);
      chk($sformatf("reset flush oe %0d", i), 16'(dq_oe), 16'd0);
    end
    chk("reset flush init", 16'(init_done), 16'd0);
    chk("reset flush refresh", rc, 16'd0);

    rst();
    go(LMR, 0, 13'h050);
    chk("bad cl err", 16'(err_flag), 16'd1);
    chk("bad cl init", 16'(init_done), 16'd1);
    go(ACT, 0, 13'h000);
    go(WR, 0, 13'h001, 16'h0F0F);
    go(RD, 0, 13'h001);
    go(NOP);
    go(NOP);
    chk("bad cl keeps 3 early", 16'(dq_oe), 16'd0);
    go(NOP);
    chk("bad cl keeps 3 oe", 16'(dq_oe), 16'd1);
    chk("bad cl keeps 3 data", dq_out, 16'h0F0F);
    rst();
    go(LMR, 0, 13'h031);
    chk("bad burst err", 16'(err_flag), 16'd1);

    rst();
    go(LMR, 0, 13'h030);
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [3:0] c;
      logic [12:0] a;
      r = $urandom_range(0, 99);
      a = 13'($urandom);
      c = r < 20 ? NOP : r < 35 ? ACT : r < 60 ? RD : r < 80 ? WR : r < 88 ? PRE :
          r < 91 ? REF : r < 94 ? {1'b1, 3'($urandom)} : r < 97 ? BST : LMR;
      if (c == RD || c == WR) a = a & 13'h1C0F;
      if (c == LMR) begin
        if (tick - last_rd > 4) a = lm_tab[$urandom_range(0, 4)];
        else c = NOP;
      end
      if ($urandom_range(0, 299) == 0) begin
        rst();
        go(LMR, 0, $urandom_range(0, 1) ? 13'h020 : 13'h030);
      end else
        step(1'b0, $urandom_range(0, 9) != 0, c, 2'($urandom), a,
             $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable single-data-rate SDRAM device responder: the device end of the 16-bit SDRAM pin interface driven by the Nios platform's SDRAM controller (addr/ba/cas_n/cke/cs_n/dq/dqm/ras_n/we_n).
- Decodes controller commands, tracks per-bank open rows, stores write data in a small folded on-chip array, and returns read data after the programmed CAS latency.
- Used as the in-fabric or testbench partner for the controller, so controller and firmware memory traffic can be checked without the external DRAM.

Parameters:
- COL_BITS, 10, column address width taken from addr[COL_BITS-1:0].
- ROW_FOLD_BITS, 2, low row bits kept in the storage index.
- DEFAULT_CL, 3, CAS latency in force until the first LOAD MODE (legal: 2 or 3).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sdram_addr  in  13  row/column/mode address.
- sdram_ba  in  2  bank select.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  in  1 each  command strobes.
- sdram_cke  in  1  clock enable.
- sdram_dqm  in  2  byte masks {UDQM,LDQM}.
- sdram_dq_in  in  16  write data from controller.
- sdram_dq_out  out  16  read data.
- sdram_dq_oe  out  1  high while responder drives DQ.
- init_done  out  1  set by first LOAD MODE.
- err_flag  out  1  sticky protocol-violation flag.
- refresh_count  out  16  AUTO REFRESH commands received; wraps at 0xFFFF.

Behaviour:
- Reset values: dq_out=0, dq_oe=0, init_done=0, err_flag=0, refresh_count=0, all banks idle, CL=DEFAULT_CL, read pipeline flushed. Storage contents are not reset.
- A command is sampled only when cke=1. When cke=0, nothing is decoded and the read pipeline holds (clock suspend).
- Command decode {cs_n,ras_n,cas_n,we_n}:
  - 1xxx: INHIBIT.
  - 0111: NOP.
  - 0011: ACTIVE.
  - 0101: READ.
  - 0100: WRITE.
  - 0010: PRECHARGE.
  - 0001: AUTO REFRESH.
  - 0000: LOAD MODE.
  - 0110 (burst terminate): treated as NOP.
- State machine: UNINIT -> READY on LOAD MODE. In UNINIT, ACTIVE, READ and WRITE set err_flag and are otherwise ignored.
- LOAD MODE:
  - CL = addr[6:4]. Values 2 and 3 are accepted; any other value sets err_flag and CL stays unchanged.
  - Burst length is addr[2:0] and must be 000 (BL=1); any other value sets err_flag.
  - Legal while any bank is open, but also sets err_flag.
- Bank tracking: per bank, an open bit and row[ROW_FOLD_BITS-1:0].
  - ACTIVE on an open bank: err_flag is set and the row is reloaded.
  - PRECHARGE with addr[10]=1 closes all banks; otherwise it closes bank ba.
  - AUTO REFRESH while any bank is open sets err_flag. refresh_count increments regardless.
- Storage: 2^(2+ROW_FOLD_BITS+COL_BITS) x 16 bits, default 2^14 words. Index = {ba, open_row[ba], addr[COL_BITS-1:0]}.
- WRITE to an open bank:
  - Writes dq_in in the same cycle as the command.
  - Byte lanes with dqm bit=1 are not written.
  - WRITE to a closed bank sets err_flag and writes nothing.
- READ to an open bank:
  - Read data is fetched immediately and pushed into a depth-3 pipeline.
  - dq_oe=1 and dq_out=data exactly CL cycles after the command edge (CL cycles counted with cke=1).
  - dqm sampled 2 cycles after the READ command: if both bits=1, dq_oe stays 0 for that slot. Partial masks still drive both bytes.
  - READ to a closed bank sets err_flag and produces no output.
- Back-to-back READs: one result per cycle, no gaps; dq_oe stays high continuously.
- WRITE issued while read data is still pending: the pending reads complete normally, the write is accepted, and err_flag is set (bus contention).
- Same-cycle read and write to the same index is impossible (one command per cycle). A READ issued the cycle after a WRITE returns the new data.
- reset asserted mid-burst: pipeline flushed, dq_oe=0 on the next cycle, state returns to UNINIT.

Test Plan:
- Reset, then issue READ with no prior LOAD MODE -> err_flag=1, dq_oe stays 0, init_done=0.
- LOAD MODE addr=0x030, ACTIVE ba=1 row=0x0005, WRITE col=0x012 data=0xBEEF dqm=00, READ col=0x012 -> dq_out=0xBEEF with dq_oe=1 exactly 3 cycles after READ; init_done=1; err_flag=0.
- LOAD MODE addr=0x020 (CL=2), write 0x1234, WRITE same column 0xABCD with dqm=01, READ -> 0xAB34 appears 2 cycles after READ.
- Four back-to-back READs to cols 0..3 holding 0x0001..0x0004 -> dq_oe high 4 consecutive cycles, data 1,2,3,4 in order; with cke=0 for one cycle mid-burst -> output holds one extra cycle.
- PRECHARGE all (addr[10]=1), then 3 AUTO REFRESH -> refresh_count=3, err_flag=0; then WRITE without ACTIVE -> err_flag=1, memory unchanged on re-read.
- Assert reset one cycle after READ at CL=3 -> dq_oe never asserts for that read; init_done=0; refresh_count=0.
